// File: rtl/bf_bus_pkg.sv
// Shared definitions for the memory bus interface.
//   - PHASE_* : encodings driven on bus_phase
//   - state_t : handshake controller states
//   - decode_phase() : maps the FSM addr/write strobes onto a bus phase
package bf_bus_pkg;

  localparam logic [1:0] PHASE_ADDR  = 2'd0;
  localparam logic [1:0] PHASE_WRITE = 2'd1;
  localparam logic [1:0] PHASE_READ  = 2'd2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StRel  = 2'd2,
    StDone = 2'd3
  } state_t;

  // An address phase wins over a write strobe.
  function automatic logic [1:0] decode_phase(input logic addr, input logic write);
    if (addr) begin
      return PHASE_ADDR;
    end else if (write) begin
      return PHASE_WRITE;
    end
    return PHASE_READ;
  endfunction

endpackage

// File: rtl/ack_sync.sv
// Synchroniser for the asynchronous bus acknowledge.
//   clk, nreset : system clock, synchronous active-low reset
//   ack         : raw acknowledge from the external bus
//   ack_synced  : acknowledge after SYNC_STAGES flops (1..3)
module ack_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic nreset,
  input  logic ack,
  output logic ack_synced
);

  if (SYNC_STAGES < 1 || SYNC_STAGES > 3) begin : g_bad_stages
    $error("ack_sync: SYNC_STAGES must be in 1..3");
  end

  logic [SYNC_STAGES-1:0] sync_q;

  if (SYNC_STAGES == 1) begin : g_single
    always_ff @(posedge clk) begin
      if (!nreset) begin
        sync_q <= '0;
      end else begin
        sync_q <= ack;
      end
    end
  end else begin : g_chain
    always_ff @(posedge clk) begin
      if (!nreset) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], ack};
      end
    end
  end

  assign ack_synced = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/mem_bus_if.sv
// Memory bus interface: turns per-state CPU bus requests into a four-phase
// req/ack handshake on the 8-bit external bus.
//   clk, nreset          : system clock, synchronous active-low reset
//   cpu_valid            : transfer request, sampled only while idle
//   cpu_write, cpu_addr  : FSM strobes selecting WRITE / ADDR (else READ)
//   cpu_wdata            : address or data to drive
//   cpu_rdata            : captured read data, held until the next read
//   cpu_ready            : one-cycle completion pulse
//   cpu_err              : timeout flag, valid with cpu_ready
//   bus_out, bus_oe      : external bus drive value and output enable
//   bus_in               : external bus input
//   bus_phase            : 0 = ADDR, 1 = WRITE, 2 = READ
//   bus_strobe, bus_ack  : handshake request / asynchronous acknowledge
// Build option: define BF_BUS_TIMEOUT_EN to enable the TIMEOUT_CYCLES watchdog.
module mem_bus_if
  import bf_bus_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       cpu_valid,
  input  logic       cpu_write,
  input  logic       cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       cpu_ready,
  output logic       cpu_err,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  input  logic [7:0] bus_in,
  output logic [1:0] bus_phase,
  output logic       bus_strobe,
  input  logic       bus_ack
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_bus_if: TIMEOUT_CYCLES must be at least 1");
  end

  state_t     state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       ack_s;

  ack_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk       (clk),
    .nreset    (nreset),
    .ack       (bus_ack),
    .ack_synced(ack_s)
  );

`ifdef BF_BUS_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= StIdle;
      phase_q <= PHASE_ADDR;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef BF_BUS_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (cpu_valid) begin
          phase_d = decode_phase(cpu_addr, cpu_write);
          wdata_d = cpu_wdata;
          state_d = StReq;
`ifdef BF_BUS_TIMEOUT_EN
          cnt_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      StReq: begin
        if (ack_s) begin
          // Responder keeps bus_in stable from ack rise until strobe drops.
          if (phase_q == PHASE_READ) begin
            rdata_d = bus_in;
          end
          state_d = StRel;
        end
      end
      StRel: begin
        if (!ack_s) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

`ifdef BF_BUS_TIMEOUT_EN
    // Watchdog overrides the handshake once the limit is reached.
    if (state_q == StReq || state_q == StRel) begin
      cnt_d = cnt_q + CntW'(1);
      if (cnt_q == TimeoutLast) begin
        state_d = StDone;
        err_d   = 1'b1;
        if (phase_q == PHASE_READ) begin
          rdata_d = 8'h00;
        end
      end
    end
`endif
  end

  assign bus_strobe = (state_q == StReq);
  assign bus_oe     = (state_q == StReq || state_q == StRel) && (phase_q != PHASE_READ);
  assign bus_out    = wdata_q;
  assign bus_phase  = phase_q;
  assign cpu_rdata  = rdata_q;
  assign cpu_ready  = (state_q == StDone);

`ifdef BF_BUS_TIMEOUT_EN
  assign cpu_err = (state_q == StDone) && err_q;
`else
  assign cpu_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_if.sv
module tb_mem_bus_if;
  import bf_bus_pkg::*;

  localparam int unsigned S  = 2;
  localparam int unsigned TO = 20;
  localparam int DEAD = 1000000;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       cpu_valid = 1'b0, cpu_write = 1'b0, cpu_addr = 1'b0;
  logic [7:0] cpu_wdata = 8'h00;
  logic [7:0] cpu_rdata;
  logic       cpu_ready, cpu_err;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic [7:0] bus_in = 8'h00;
  logic [1:0] bus_phase;
  logic       bus_strobe;
  logic       bus_ack;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_rdata = 8'h00;

  mem_bus_if #(
    .SYNC_STAGES   (S),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .nreset    (nreset),
    .cpu_valid (cpu_valid),
    .cpu_write (cpu_write),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .cpu_err   (cpu_err),
    .bus_out   (bus_out),
    .bus_oe    (bus_oe),
    .bus_in    (bus_in),
    .bus_phase (bus_phase),
    .bus_strobe(bus_strobe),
    .bus_ack   (bus_ack)
  );

  always #5 clk = ~clk;

  // Responder: ack rises rise_dly cycles after strobe rises, falls fall_dly
  // cycles after strobe falls (zero = combinational follow).
  int   rise_dly = 0, fall_dly = 0, hi_cnt = 0, lo_cnt = 0;
  logic ack_lvl = 1'b0;

  always @(posedge clk) begin
    if (bus_strobe) begin
      hi_cnt <= hi_cnt + 1;
      lo_cnt <= 0;
    end else begin
      lo_cnt <= lo_cnt + 1;
      hi_cnt <= 0;
    end
    ack_lvl <= bus_ack;
  end

  always_comb begin
    bus_ack = 1'b0;
    if (bus_strobe) bus_ack = ack_lvl || (hi_cnt >= rise_dly);
    else            bus_ack = ack_lvl && (lo_cnt < fall_dly);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transfer; returns in the idle cycle following the ready pulse.
  task automatic xfer(input string tag, input logic [1:0] ph, input logic [7:0] wd,
                      input logic [7:0] resp, input int rise, input int fall,
                      input bit keep);
    int edges, lat, exp_lat;
    bit ok, done;
    rise_dly  = rise;
    fall_dly  = fall;
    bus_in    = resp;
    cpu_valid = 1'b1;
    cpu_addr  = (ph == PHASE_ADDR);
    cpu_write = (ph == PHASE_WRITE) || (ph == PHASE_ADDR && $urandom_range(0, 1) == 1);
    cpu_wdata = wd;
    edges = 0;
    do begin
      tick();
      edges++;
    end while (!bus_strobe && edges < 4);
    check({tag, ".accept_edges"}, edges, 1);
    if (!keep) begin
      cpu_valid = 1'b0;
      cpu_wdata = 8'($urandom);
      cpu_addr  = 1'($urandom);
      cpu_write = 1'($urandom);
    end
    if (ph == PHASE_READ) exp_rdata = resp;
    exp_lat = 2 * S + 2 + rise + fall;
    lat  = 0;
    ok   = 1'b1;
    done = 1'b0;
    while (!done && lat < exp_lat + 50) begin
      if (bus_strobe && (bus_out !== wd || bus_phase !== ph || bus_oe !== (ph != PHASE_READ)))
        ok = 1'b0;
      if (ph == PHASE_READ && bus_oe !== 1'b0) ok = 1'b0;
      if (cpu_ready === 1'b1) done = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
    check({tag, ".ready_seen"}, done, 1);
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".bus_drive"}, ok, 1);
    check({tag, ".rdata"}, cpu_rdata, exp_rdata);
    check({tag, ".err"}, cpu_err, 0);
    tick();
    check({tag, ".single_pulse"}, {cpu_ready, bus_strobe}, 2'b00);
  endtask

  initial begin
    logic [1:0] ph;
    int lat;
    bit seen;

    // Reset state
    nreset = 1'b0;
    tick();
    tick();
    check("rst.outputs", {bus_strobe, bus_oe, cpu_ready, cpu_err, bus_phase},
          {1'b0, 1'b0, 1'b0, 1'b0, PHASE_ADDR});
    check("rst.data", {bus_out, cpu_rdata}, 16'h0000);
    nreset = 1'b1;
    tick();

    // Directed transfers
    xfer("addr2a", PHASE_ADDR, 8'h2A, 8'hC3, 0, 0, 1'b0);
    xfer("read5b", PHASE_READ, 8'h99, 8'h5B, 0, 0, 1'b0);
    xfer("write07", PHASE_WRITE, 8'h07, 8'hEE, 0, 0, 1'b0);
    xfer("slow", PHASE_WRITE, 8'h3C, 8'h00, 10, 3, 1'b0);

    // Back-to-back with cpu_valid held
    xfer("b2b_addr", PHASE_ADDR, 8'h10, 8'h00, 0, 0, 1'b1);
    xfer("b2b_write", PHASE_WRITE, 8'hFF, 8'h00, 0, 0, 1'b0);

    // Reset during REQ
    rise_dly  = DEAD;
    cpu_valid = 1'b1;
    cpu_addr  = 1'b1;
    cpu_wdata = 8'h44;
    tick();
    cpu_valid = 1'b0;
    check("rstmid.in_req", {bus_strobe, bus_oe}, 2'b11);
    tick();
    nreset = 1'b0;
    tick();
    check("rstmid.dropped", {bus_strobe, bus_oe, cpu_ready}, 3'b000);
    nreset = 1'b1;
    exp_rdata = 8'h00;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cpu_ready === 1'b1 || bus_strobe === 1'b1) seen = 1'b1;
    end
    check("rstmid.quiet", seen, 0);
    check("rstmid.rdata", cpu_rdata, exp_rdata);
    xfer("rstmid_read", PHASE_READ, 8'h00, 8'hA6, 1, 2, 1'b0);

    // Randomised transfers
    for (int n = 0; n < 14; n++) begin
      ph = 2'($urandom_range(0, 2));
      xfer("rand", ph, 8'($urandom), 8'($urandom), $urandom_range(0, 5),
           $urandom_range(0, 5), 1'b0);
    end

    // Dead responder
    rise_dly  = DEAD;
    cpu_valid = 1'b1;
    cpu_addr  = 1'b0;
    cpu_write = 1'b0;
    cpu_wdata = 8'h00;
    tick();
    cpu_valid = 1'b0;
`ifdef BF_BUS_TIMEOUT_EN
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 60) begin
      if (cpu_ready === 1'b1) seen = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
    exp_rdata = 8'h00;
    check("timeout.ready_seen", seen, 1);
    check("timeout.window", (lat >= TO - 1 && lat <= TO + 2), 1);
    check("timeout.err", cpu_err, 1);
    check("timeout.rdata", cpu_rdata, exp_rdata);
    tick();
    check("timeout.single_pulse", cpu_ready, 0);
    xfer("after_timeout", PHASE_READ, 8'h00, 8'h6D, 0, 0, 1'b0);
`else
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (cpu_ready === 1'b1 || cpu_err === 1'b1) seen = 1'b1;
    end
    check("noto.never_ready", seen, 0);
    check("noto.still_waiting", bus_strobe, 1);
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    exp_rdata = 8'h00;
    xfer("after_dead", PHASE_READ, 8'h00, 8'h6D, 0, 0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
